rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter_pkg.sv | 13 +
 rtl/rr_pick.sv | 36 +++
 rtl/rr_arbiter.sv | 107 ++++++++++
 tb/tb_rr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared constants for the arbiter and encoder blocks: requester count,
// index width and the IDLE/BUSY state encoding.
package rr_arbiter_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate req so the search starts at last_id+1,
// then take the lowest set bit.
module rr_pick
  import rr_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_id,
  output logic [IdxW-1:0]   winner_id,
  output logic              found
);

  logic [IdxW:0]       shift;
  logic [2*NumReq-1:0] dbl;
  logic [NumReq-1:0]   rot;
  logic [IdxW-1:0]     offset;

  assign shift = {1'b0, last_id} + {{IdxW{1'b0}}, 1'b1};
  assign dbl   = {req, req} >> shift;
  assign rot   = dbl[NumReq-1:0];

  // Scan high to low so the lowest set bit (nearest to last_id+1) wins.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found  = 1'b1;
        offset = IdxW'(i);
      end
    end
  end

  // Index arithmetic wraps naturally modulo NumReq.
  assign winner_id = last_id + IdxW'(1) + offset;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over 8 requesters with a bounded hold time; a grant ends
// on the done strobe, holder request drop, or hold limit.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              rel,
  output logic [NumReq-1:0] grant,
  output logic              grant_valid,
  output logic [IdxW-1:0]   grant_id,
  output logic              timeout
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]     last_id_q, last_id_d;
  logic [IdxW-1:0]     grant_id_q, grant_id_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;

  logic [IdxW-1:0]     pick_id;
  logic                pick_found;
  logic                at_limit;
  logic                holder_req;

  rr_pick u_pick (
    .req       (req),
    .last_id   (last_id_q),
    .winner_id (pick_id),
    .found     (pick_found)
  );

  assign at_limit   = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign holder_req = req[grant_id_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_id_d  = last_id_q;
    grant_id_d = grant_id_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_found) begin
          state_d    = StBusy;
          grant_d    = {{(NumReq - 1){1'b0}}, 1'b1} << pick_id;
          grant_id_d = pick_id;
          valid_d    = 1'b1;
          last_id_d  = pick_id;
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
          valid_d    = 1'b0;
        end
      end
      StBusy: begin
        if (rel || !holder_req || at_limit) begin
          state_d    = StIdle;
          cnt_d      = '0;
          grant_d    = '0;
          grant_id_d = '0;
          valid_d    = 1'b0;
          // Pulse only when the hold limit alone ended the grant.
          timeout_d  = at_limit && !rel && holder_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_id_q  <= IdxW'(NumReq - 1);
      grant_id_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_id_q  <= last_id_d;
      grant_id_q <= grant_id_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with hand-computed expected grants.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter #(
    .HOLD_MAX (16),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the edge; inputs change at the same point.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] exp_id, input logic exp_valid,
                           input logic exp_to);
    logic [7:0] exp_grant;
    exp_grant = exp_valid ? (8'h01 << exp_id) : 8'h00;
    check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    check({tag, ".valid"}, 32'(grant_valid), 32'(exp_valid));
    check({tag, ".id"}, 32'(grant_id), exp_valid ? 32'(exp_id) : 32'd0);
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    rel = 1'b0;
    tick(2);
    check_out("reset", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic grant then release and rotation to the next requester.
    req = 8'h05;
    tick(1);
    check_out("first_grant", 3'd0, 1'b1, 1'b0);
    rel = 1'b1;
    tick(1);
    check_out("release_idle", 3'd0, 1'b0, 1'b0);
    rel = 1'b0;
    tick(1);
    check_out("second_grant", 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    tick(1);
    check_out("drop_idle", 3'd0, 1'b0, 1'b0);
    tick(1);
    check_out("stay_idle", 3'd0, 1'b0, 1'b0);

    // Full rotation with every holder releasing after one cycle.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      check_out($sformatf("rot%0d", k), 3'(k % 8), 1'b1, 1'b0);
      rel = 1'b1;
      tick(1);
      check_out($sformatf("rot_gap%0d", k), 3'd0, 1'b0, 1'b0);
      rel = 1'b0;
    end
    req = 8'h00;
    tick(1);

    // Hold limit: 16 grant cycles, one timeout idle, then regrant to 3.
    do_reset();
    req = 8'h08;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      check_out($sformatf("hold%0d", k), 3'd3, 1'b1, 1'b0);
    end
    tick(1);
    check_out("hold_timeout", 3'd0, 1'b0, 1'b1);
    tick(1);
    check_out("hold_regrant", 3'd3, 1'b1, 1'b0);

    // Holder 3 times out while 7 also requests; 7 must not pre-empt, then wins.
    req = 8'h88;
    for (int k = 1; k < 16; k++) begin
      tick(1);
      check_out($sformatf("nopreempt%0d", k), 3'd3, 1'b1, 1'b0);
    end
    tick(1);
    check_out("rr_timeout", 3'd0, 1'b0, 1'b1);
    tick(1);
    check_out("rr_next7", 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    tick(1);
    check_out("rr_drop", 3'd0, 1'b0, 1'b0);

    // Release coinciding with the hold limit gives no timeout.
    do_reset();
    req = 8'h01;
    tick(16);
    check_out("lim_last", 3'd0, 1'b1, 1'b0);
    rel = 1'b1;
    tick(1);
    check_out("lim_release", 3'd0, 1'b0, 1'b0);
    rel = 1'b0;

    // Request drop coinciding with the hold limit gives no timeout.
    tick(1);
    check_out("lim2_grant", 3'd0, 1'b1, 1'b0);
    tick(15);
    req = 8'h00;
    tick(1);
    check_out("lim_drop", 3'd0, 1'b0, 1'b0);

    // Reset mid-BUSY revokes the grant; search restarts at requester 0.
    req = 8'h40;
    tick(1);
    check_out("pre_rst", 3'd6, 1'b1, 1'b0);
    tick(2);
    rst = 1'b1;
    rel = 1'b1;
    tick(1);
    check_out("mid_rst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    rel = 1'b0;
    req = 8'h81;
    tick(1);
    check_out("post_rst0", 3'd0, 1'b1, 1'b0);
    do_reset();
    req = 8'h80;
    tick(1);
    check_out("post_rst7", 3'd7, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
